// File: rtl/ascii_line_parser_if.sv
// Bus bundle for ascii_line_parser: file-loader read port and the parsed-number stream.
// Read port: rd_data is valid the cycle after rd_en. Stream: a transfer happens on any cycle with
// num_valid && num_ready; num_valid/num_data stay stable until that transfer, and num_valid
// never depends combinationally on num_ready.
interface ascii_line_parser_if #(
  parameter int OUT_WIDTH = 64
) ();
  logic                 rd_en;
  logic [63:0]          rd_addr;
  logic [63:0]          rd_data;
  logic                 num_valid;
  logic                 num_ready;
  logic [OUT_WIDTH-1:0] num_data;

  modport master (
    output rd_en, rd_addr, num_valid, num_data,
    input  rd_data, num_ready
  );

  modport slave (
    input  rd_en, rd_addr, num_valid, num_data,
    output rd_data, num_ready
  );
endinterface

// File: rtl/ascii_line_parser.sv
// Fetches 64-bit words from a file loader and scans them byte by byte as newline-separated
// ASCII decimal, emitting one unsigned number per non-empty line until the first NUL.
module ascii_line_parser #(
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  ascii_line_parser_if.master   bus,
  output logic [CNT_WIDTH-1:0]  num_count,
  output logic                  done,
  output logic                  overflow,
  output logic                  bad_char,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SCAN  = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int PW = OUT_WIDTH + 4;

  state_t               state, state_nxt;
  logic [63:0]          addr;
  logic [63:0]          word_buf;
  logic [2:0]           idx;
  logic [OUT_WIDTH-1:0] acc;
  logic                 digit_seen;
  logic                 end_nul;
  logic [CNT_WIDTH-1:0] count;
  logic                 ovf_r;
  logic                 bad_r;

  logic [7:0]           cur_byte;
  logic                 is_digit, is_nl, is_cr, is_nul, last_byte;
  logic [PW-1:0]        prod;

  assign cur_byte  = word_buf[{idx, 3'b000} +: 8];
  assign is_digit  = (cur_byte >= 8'h30) && (cur_byte <= 8'h39);
  assign is_nl     = (cur_byte == 8'h0A);
  assign is_cr     = (cur_byte == 8'h0D);
  assign is_nul    = (cur_byte == 8'h00);
  assign last_byte = (idx == 3'd7);
  // Extra 4 bits catch any carry past OUT_WIDTH from acc*10 + digit.
  assign prod      = PW'(acc) * PW'(10) + PW'(cur_byte - 8'h30);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_SCAN;
      S_SCAN: begin
        if (is_nl && digit_seen)  state_nxt = S_EMIT;
        else if (is_nul)          state_nxt = digit_seen ? S_EMIT : S_DONE;
        else if (last_byte)       state_nxt = S_FETCH;
        else                      state_nxt = S_SCAN;
      end
      S_EMIT: begin
        if (bus.num_ready) begin
          if (end_nul)        state_nxt = S_DONE;
          else if (last_byte) state_nxt = S_FETCH;
          else                state_nxt = S_SCAN;
        end
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  logic rd_en_c, num_valid_c, done_c;
  always_comb begin
    rd_en_c     = 1'b0;
    num_valid_c = 1'b0;
    done_c      = 1'b0;
    case (state)
      S_FETCH: rd_en_c     = 1'b1;
      S_EMIT:  num_valid_c = 1'b1;
      S_DONE:  done_c      = 1'b1;
      default: ;
    endcase
  end

  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr   = addr;
  assign bus.num_valid = num_valid_c;
  assign bus.num_data  = acc;
  assign done          = done_c;
  assign num_count     = count;
  assign overflow      = ovf_r;
  assign bad_char      = bad_r;
  assign state_dbg     = state;

  // Datapath; acc is only cleared by a transfer, so num_data is stable through a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      word_buf   <= '0;
      idx        <= '0;
      acc        <= '0;
      digit_seen <= 1'b0;
      end_nul    <= 1'b0;
      count      <= '0;
      ovf_r      <= 1'b0;
      bad_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr       <= '0;
            idx        <= '0;
            acc        <= '0;
            digit_seen <= 1'b0;
            end_nul    <= 1'b0;
            count      <= '0;
            ovf_r      <= 1'b0;
            bad_r      <= 1'b0;
          end
        end
        S_LOAD: begin
          word_buf <= bus.rd_data;
          idx      <= '0;
        end
        S_SCAN: begin
          if (is_nul) begin
            end_nul <= digit_seen;
          end else if (is_nl && digit_seen) begin
            end_nul <= 1'b0;
          end else begin
            if (is_digit) begin
              acc        <= prod[OUT_WIDTH-1:0];
              digit_seen <= 1'b1;
              if (prod[PW-1:OUT_WIDTH] != '0) ovf_r <= 1'b1;
            end else if (!is_nl && !is_cr) begin
              bad_r <= 1'b1;
            end
            if (last_byte) addr <= addr + 64'd8;
            else           idx  <= idx + 3'd1;
          end
        end
        S_EMIT: begin
          if (bus.num_ready) begin
            acc        <= '0;
            digit_seen <= 1'b0;
            count      <= count + CNT_WIDTH'(1);
            if (!end_nul) begin
              if (last_byte) addr <= addr + 64'd8;
              else           idx  <= idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_line_parser.sv
// Bench for ascii_line_parser: byte-memory loader, ready driver, reference line parser,
// scoreboard monitor on the number stream and read port, and a final report.
module tb_ascii_line_parser;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  ascii_line_parser_if bus ();
  logic [31:0] num_count;
  logic        done, overflow, bad_char;
  logic [2:0]  state_dbg;

  ascii_line_parser dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .num_count (num_count),
    .done      (done),
    .overflow  (overflow),
    .bad_char  (bad_char),
    .state_dbg (state_dbg)
  );

  // File loader: 512-byte image, word returned the cycle after rd_en
  logic [7:0] mem [0:511];
  always @(posedge clk) begin
    logic [63:0] w;
    if (bus.rd_en) begin
      for (int k = 0; k < 8; k++) w[k*8 +: 8] = mem[(int'(bus.rd_addr[8:0]) + k) % 512];
      bus.rd_data <= w;
    end
  end

  // Scoreboard state
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          xfer_cnt = 0;
  int          read_cnt = 0;
  int          exp_reads = 0;
  int          exp_count = 0;
  logic        exp_ovf, exp_bad;
  int          ready_mode = 0;
  int          stall_cnt = 0;
  logic        held = 1'b0;
  logic [63:0] held_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready driver: settles just after each rising edge
  initial begin
    bus.num_ready = 1'b0;
    bus.rd_data   = '0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: bus.num_ready = 1'b1;
        1: bus.num_ready = 1'($urandom_range(0, 1));
        2: begin
          if (bus.num_valid && xfer_cnt == 0) begin
            stall_cnt++;
            bus.num_ready = (stall_cnt > 5);
          end else begin
            bus.num_ready = 1'b1;
          end
        end
        default: bus.num_ready = 1'b0;
      endcase
    end
  end

  // Monitor: read addresses, stalls and transfers
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid_held", 64'(bus.num_valid), 64'd1);
          check("stall_data_stable", bus.num_data, held_data);
          held = 1'b0;
        end
        if (bus.rd_en) begin
          check("rd_addr", bus.rd_addr, 64'(read_cnt) * 64'd8);
          read_cnt++;
        end
        if (bus.num_valid) check("no_read_in_emit", 64'(bus.rd_en), 64'd0);
        if (bus.num_valid && bus.num_ready) begin
          if (exp_q.size() == 0) check("unexpected_num", bus.num_data, 64'hFFFF_FFFF_FFFF_FFFF);
          else                   check("num_data", bus.num_data, exp_q.pop_front());
          check("num_count_before_xfer", 64'(num_count), 64'(xfer_cnt));
          xfer_cnt++;
        end else if (bus.num_valid) begin
          held      = 1'b1;
          held_data = bus.num_data;
        end
      end
    end
  end

  // Reference model: split the image into lines up to the first NUL
  task automatic build_model();
    logic [127:0] a;
    logic         seen;
    int           i;
    a = '0; seen = 1'b0; exp_ovf = 1'b0; exp_bad = 1'b0;
    exp_q.delete();
    i = 0;
    while (mem[i] != 8'h00) begin
      if (mem[i] >= "0" && mem[i] <= "9") begin
        a = a * 128'd10 + 128'(mem[i] - "0");
        if (a[127:64] != 0) exp_ovf = 1'b1;
        a[127:64] = '0;
        seen = 1'b1;
      end else if (mem[i] == 8'h0A) begin
        if (seen) exp_q.push_back(a[63:0]);
        a = '0; seen = 1'b0;
      end else if (mem[i] != 8'h0D) begin
        exp_bad = 1'b1;
      end
      i++;
    end
    if (seen) exp_q.push_back(a[63:0]);
    exp_reads = i / 8 + 1;
    exp_count = exp_q.size();
  endtask

  // Driver tasks
  task automatic load_str(input string s);
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
  endtask

  task automatic gen_random();
    int pos, nlines, kind, nd;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    pos = 0;
    nlines = $urandom_range(1, 10);
    for (int l = 0; l < nlines && pos < 440; l++) begin
      kind = $urandom_range(0, 9);
      if (kind == 1) begin mem[pos] = 8'h0D; pos++; end
      if (kind >= 2) begin
        nd = (kind == 9) ? $urandom_range(15, 24) : $urandom_range(1, 7);
        for (int d = 0; d < nd; d++) begin
          if ($urandom_range(0, 30) == 0) mem[pos] = 8'($urandom_range(8'h21, 8'h2F));
          else                            mem[pos] = 8'($urandom_range(8'h30, 8'h39));
          pos++;
        end
        if ($urandom_range(0, 3) == 0) begin mem[pos] = 8'h0D; pos++; end
      end
      if (l < nlines - 1 || $urandom_range(0, 1) == 1) begin mem[pos] = 8'h0A; pos++; end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_case(input int mode);
    build_model();
    xfer_cnt = 0; read_cnt = 0; stall_cnt = 0; ready_mode = mode;
    pulse_start();
    for (int c = 0; c < 4000 && !done; c++) @(negedge clk);
    check("done_reached", 64'(done), 64'd1);
    @(negedge clk);
    check("done_held", 64'(done), 64'd1);
    check("final_num_count", 64'(num_count), 64'(exp_count));
    check("all_numbers_seen", 64'(exp_q.size()), 64'd0);
    check("overflow_flag", 64'(overflow), 64'(exp_ovf));
    check("bad_char_flag", 64'(bad_char), 64'(exp_bad));
    check("read_count", 64'(read_cnt), 64'(exp_reads));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},     64'(bus.rd_en), 64'd0);
    check({tag, "_rd_addr"},   bus.rd_addr, 64'd0);
    check({tag, "_num_valid"}, 64'(bus.num_valid), 64'd0);
    check({tag, "_num_data"},  bus.num_data, 64'd0);
    check({tag, "_num_count"}, 64'(num_count), 64'd0);
    check({tag, "_done"},      64'(done), 64'd0);
    check({tag, "_overflow"},  64'(overflow), 64'd0);
    check({tag, "_bad_char"},  64'(bad_char), 64'd0);
  endtask

  // Main sequence and final report
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    load_str("12\n3456\n");                             run_case(0);
    load_str("12\n3456\n");                             run_case(2);
    load_str("100756");                                 run_case(0);
    load_str("\015\n\n7\015\n");                        run_case(0);
    load_str("99999999999999999999\n");                 run_case(0);
    load_str("1x2\n");                                  run_case(0);
    load_str("5\n\n\n\n\n\n\n\n\n\n\n42\n");            run_case(1);

    // Abort mid-EMIT with the stream stalled
    load_str("12\n3456\n");
    build_model();
    xfer_cnt = 0; read_cnt = 0; ready_mode = 3;
    pulse_start();
    for (int c = 0; c < 100 && !bus.num_valid; c++) @(negedge clk);
    check("emit_before_reset", 64'(bus.num_valid), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk); rst = 1'b1;
    run_case(0);

    for (int r = 0; r < 30; r++) begin
      gen_random();
      run_case(int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
